// File: rtl/ps2_pkg.sv
// Shared types, frame constants and the parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    // A frame is good when data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO: dout always holds the head entry while not empty.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned PW    = FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 do_pop, do_push;

    // Pop is resolved first so a push into a full FIFO that is being read is kept.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        dout_d  = dout_q;
        if (do_push || do_pop) begin
            dout_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM and scancode FIFO.
// Define PS2_WATCHDOG_EN to add an inter-edge timeout that abandons truncated frames.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned FIFO_LOG2  = 3,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    input  logic                 rd,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 overflow,
    output logic                 parity_err
);

    localparam int unsigned FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned BCW = $clog2(DATA_BITS);

    logic [1:0]           clk_sync_q, dat_sync_q;
    logic                 filt_q, filt_d, filt_prev_q;
    logic [FCW-1:0]       fcnt_q, fcnt_d;
    logic                 fall_c;
    logic                 dat;

    ps2_state_e           state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 push_q, push_d;
    logic                 perr_set;
    logic                 ovf_q, ovf_d;
    logic                 perr_q, perr_d;
    logic                 fifo_empty, fifo_full;
    logic                 wdog_expired_c;

    assign dat    = dat_sync_q[1];
    assign fall_c = filt_prev_q & ~filt_q;

    // Filtered clock flips only after FILTER_LEN consecutive samples at the new level.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned WDOG_CYC =
        32'((64'(CLK_HZ) * 64'(TIMEOUT_US) + 64'd999999) / 64'd1000000);
    localparam int unsigned WCW = $clog2(WDOG_CYC + 1);

    logic [WCW-1:0] wdog_q, wdog_d;

    // Reloads on each falling edge; runs down only while a frame is in progress.
    always_comb begin
        wdog_d = wdog_q;
        if (fall_c) begin
            wdog_d = WCW'(WDOG_CYC);
        end else if ((state_q != ST_IDLE) && (wdog_q != '0)) begin
            wdog_d = wdog_q - WCW'(1);
        end
    end

    assign wdog_expired_c = (state_q != ST_IDLE) && (wdog_q == '0) && !fall_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= WCW'(WDOG_CYC);
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expired_c = 1'b0;
`endif

    // Frame FSM; the push is registered so it reaches the FIFO the cycle after the stop edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_d    = 1'b0;
        perr_set  = 1'b0;
        if (fall_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (dat == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if ((dat == STOP_BIT) && odd_parity_ok(shift_q, par_q)) begin
                        push_d = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (wdog_expired_c) begin
            state_d = ST_IDLE;
        end
    end

    // Sticky flags: a new error in the same cycle as clr_err wins.
    always_comb begin
        ovf_d  = (ovf_q & ~clr_err) | (push_q & fifo_full & ~rd);
        perr_d = (perr_q & ~clr_err) | perr_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
        end
    end

    ps2_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_q),
        .pop     (rd),
        .din     (shift_q),
        .dout    (data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign ready      = ~fifo_empty;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: PS/2 frames at 12.5 kHz against a 1 MHz system clock.
module tb_ps2_keyboard;

    localparam int unsigned CLK_HZ     = 1000000;
    localparam int unsigned FIFO_LOG2  = 3;
    localparam int unsigned TIMEOUT_US = 2000;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned HALF_BIT   = 40;
    // pin edge -> 2 sync -> FILTER_LEN filter -> fall -> push -> ready
    localparam int unsigned LAT        = 2 + FILTER_LEN + 2;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_dat    = 1'b1;
    logic       rd         = 1'b0;
    logic       clr_err    = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    ps2_keyboard #(
        .CLK_HZ     (CLK_HZ),
        .FIFO_LOG2  (FIFO_LOG2),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rd         (rd),
        .clr_err    (clr_err),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        tick(HALF_BIT / 2);
        ps2_clk = 1'b0;
        tick(HALF_BIT);
        ps2_clk = 1'b1;
        tick(HALF_BIT / 2);
    endtask

    // mode 0: plain frame, 1: check ready latency, 2: pulse rd on the push cycle
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        ps2_dat = 1'b1;
        tick(HALF_BIT / 2);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            tick(LAT - 1);
            check("lat_before", 32'(ready), 32'd0);
            tick(1);
            check("lat_at", 32'(ready), 32'd1);
        end else if (mode == 2) begin
            tick(LAT - 1);
            rd = 1'b1;
            tick(1);
            rd = 1'b0;
        end else begin
            tick(LAT);
        end
        tick(HALF_BIT - LAT);
        ps2_clk = 1'b1;
        tick(HALF_BIT / 2 + 40);
    endtask

    task automatic pop();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] exp_b;

        tick(3);
        check("rst_data", 32'(data), 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        reset_n = 1'b1;
        tick(10);

        // single byte with latency check
        send_frame(8'h1C, 1'b0, 1);
        check("b1c_data", 32'(data), 32'h1C);
        pop();
        check("b1c_rd_ready", 32'(ready), 32'd0);

        // break sequence F0 1C
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
        check("seq_ready", 32'(ready), 32'd1);
        check("seq_d0", 32'(data), 32'hF0);
        pop();
        check("seq_d1", 32'(data), 32'h1C);
        pop();
        check("seq_empty", 32'(ready), 32'd0);
        check("seq_perr", 32'(parity_err), 32'd0);

        // bad parity is discarded and flagged
        send_frame(8'h1C, 1'b1, 0);
        check("bp_ready", 32'(ready), 32'd0);
        check("bp_perr", 32'(parity_err), 32'd1);
        pulse_clr();
        check("bp_clr", 32'(parity_err), 32'd0);

        // overflow: nine frames into depth 8
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            exp_b = 8'(i);
            check("ovf_pop", 32'(data), 32'(exp_b));
            pop();
        end
        check("ovf_empty", 32'(ready), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        pulse_clr();
        check("ovf_clr", 32'(overflow), 32'd0);

        // full FIFO, rd coincides with push of 0x0A
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 0);
        send_frame(8'h0A, 1'b0, 2);
        check("simul_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            exp_b = (i == 9) ? 8'h0A : 8'(i);
            check("simul_pop", 32'(data), 32'(exp_b));
            pop();
        end
        check("simul_empty", 32'(ready), 32'd0);

`ifdef PS2_WATCHDOG_EN
        // truncated frame abandoned after the inter-edge timeout
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(3000);
        send_frame(8'h5A, 1'b0, 0);
        check("wd_ready", 32'(ready), 32'd1);
        check("wd_data", 32'(data), 32'h5A);
        check("wd_perr", 32'(parity_err), 32'd0);
        check("wd_ovf", 32'(overflow), 32'd0);
        pop();
`endif

        // reset mid-frame with a byte buffered and parity_err set
        send_frame(8'h33, 1'b0, 0);
        send_frame(8'h44, 1'b1, 0);
        check("pre_rst_ready", 32'(ready), 32'd1);
        check("pre_rst_perr", 32'(parity_err), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_dat = 1'b0;
        tick(HALF_BIT / 2);
        ps2_clk = 1'b0;
        tick(10);
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_perr", 32'(parity_err), 32'd0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(20);
        reset_n = 1'b1;
        tick(100);
        send_frame(8'h29, 1'b0, 0);
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_data", 32'(data), 32'h29);
        check("post_rst_perr", 32'(parity_err), 32'd0);
        pop();
        check("post_rst_empty", 32'(ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard receiver on the DE0 board. It sits upstream of the CPU port space (pr/pw) and is the input side of the text-terminal system.
- Deserialises device-to-host frames from PS2_CLK/PS2_DAT, checks framing and parity, and buffers scancodes in a small FIFO.
- Presents the head byte plus status flags for the CPU port decoder to read (data at port 60h, status at port 64h; decoding lives in the top level).

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz; used to derive the watchdog cycle count.
- FIFO_LOG2, 3, log2 of FIFO depth (default depth 8).
- TIMEOUT_US, 2000, maximum gap between PS/2 falling edges inside a frame, in µs.
- FILTER_LEN, 4, consecutive identical samples required before the filtered ps2_clk changes level.

Ports:
- clock  in  1  system clock (clock_25 in de0).
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (open-drain; the top drives it Z).
- ps2_dat  in  1  raw PS/2 data pin.
- rd  in  1  one-cycle pop strobe from the CPU port-60h read.
- clr_err  in  1  one-cycle strobe that clears overflow and parity_err.
- data  out  8  FIFO head byte; valid only while ready=1.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame with bad parity or bad stop bit was discarded.

Behaviour:
- Reset:
  - data=0, ready=0, overflow=0, parity_err=0.
  - FIFO pointers and count = 0; FSM = IDLE; synchronisers and filter = 1.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - ps2_clk then passes the FILTER_LEN glitch filter.
  - fall = one-cycle pulse on a 1→0 transition of the filtered clock. Data is sampled at fall.
- FSM (advances only on fall):
  - IDLE: if dat=0 (start bit) → DATA with bit counter=0. If dat=1, stay in IDLE.
  - DATA: shift dat in, LSB first. After 8 bits → PARITY.
  - PARITY: latch dat → STOP.
  - STOP:
    - If dat=1 and (popcount(byte)+parity) is odd → push the byte.
    - Otherwise set parity_err and do not push.
    - Always → IDLE.
- Push timing: the push happens on the cycle after the STOP fall pulse. ready rises on the following cycle (2 cycles after fall).
- FIFO:
  - Depth 2^FIFO_LOG2, show-ahead: data = mem[rd_ptr] registered, updated the same cycle the pointer moves.
  - Pointers wrap modulo depth.
  - rd while ready=0 is ignored.
  - Push while full and no rd: byte dropped, overflow=1.
  - Simultaneous rd and push:
    - Pop is applied first, so the push is always accepted, even when full.
    - Count stays unchanged.
    - Empty FIFO with simultaneous rd and push: rd is ignored and the byte is stored.
- Sticky flags:
  - Cleared only by clr_err or reset.
  - If clr_err coincides with a new error, set wins.
- Reset asserted mid-frame: partial frame discarded, FIFO emptied, all outputs return to reset values.

Optional Feature:
- Macro: PS2_WATCHDOG_EN.
- Defined:
  - A counter of ceil(CLK_HZ/1e6*TIMEOUT_US) cycles reloads on every fall.
  - If it expires while the FSM is not IDLE, the FSM returns to IDLE and the partial frame is discarded. No flag is set and the FIFO is untouched.
- Undefined:
  - No counter is present.
  - A truncated frame resynchronises only through subsequent edges or reset.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Frame constants: DATA_BITS=8, START=0, STOP=1.
  - Helper function for odd parity.
- One natural sub-module, ps2_fifo: synchronous show-ahead FIFO with parameter FIFO_LOG2, ports push/pop/din/dout/empty/full.
- The receiver FSM, filter and watchdog stay in ps2_keyboard.

Test Plan:
- Byte 0x1C, parity 0, stop 1, at a 12.5 kHz PS/2 clock → ready=1 two cycles after the last fall; data=0x1C; rd → ready=0.
- Sequence 0xF0 (parity 1), 0x1C → two pops return 0xF0 then 0x1C; parity_err=0.
- 0x1C sent with parity 1 → no push, ready stays 0, parity_err=1; clr_err → parity_err=0.
- Nine good frames 0x01..0x09 with no rd → overflow=1; eight pops return 0x01..0x08, then ready=0.
- FIFO full, rd pulsed on the push cycle of the frame carrying 0x0A → count stays 8, 0x0A stored, overflow unchanged.
- (PS2_WATCHDOG_EN) 5 edges then 3 ms idle → FSM returns to IDLE; next frame 0x5A received correctly with no error flags. Reset pulse mid-frame → all outputs 0 and next frame received cleanly.
